// File: rtl/lsu_sram_master_if.sv
// SRAM-like data bus between the LSU (master) and the data memory (slave).
// One outstanding access at a time; req/addr_ok for the address, data_ok for the response.
interface lsu_sram_master_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/lsu_sram_master.sv
// Load/store unit: alignment check, single-outstanding SRAM bus master, load formatting.
// Define UNALIGNED_LS_EN to add LWL/LWR/SWL/SWR (ls_lr_i, old_rt_i).
module lsu_sram_master (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ls_valid_i,
   input  logic                 ls_load_i,
   input  logic                 ls_store_i,
   input  logic [1:0]           ls_size_i,
   input  logic                 ls_signed_i,
   input  logic [1:0]           ls_lr_i,
   input  logic [31:0]          daddr_i,
   input  logic [31:0]          wdata_i,
   input  logic [31:0]          old_rt_i,
   input  logic                 flush_i,
   lsu_sram_master_if.master    bus,
   output logic                 stall_o,
   output logic                 done_o,
   output logic [31:0]          rdata_o,
   output logic                 adel_o,
   output logic                 ades_o,
   output logic [31:0]          badvaddr_o
);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_e;

   typedef struct packed {
      logic        wr;
      logic [1:0]  bsize;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [1:0]  off;
      logic [1:0]  lsize;
      logic        sgn;
   } req_t;

   state_e      state_q, state_d;
   req_t        req_q, req_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] ld_fmt;
   logic [7:0]  lb;
   logic [15:0] lh;
   logic        is_st, start, lr_op, misal, fault, accept;
   logic [1:0]  off;

   assign off   = daddr_i[1:0];
   assign is_st = ls_store_i & ~ls_load_i;
   // reset and flush both silence a new access in the cycle they are seen
   assign start = ls_valid_i & (ls_load_i | ls_store_i) & ~flush_i & ~rst & (state_q == S_IDLE);

`ifdef UNALIGNED_LS_EN
   logic [1:0]  lr_q, lr_d;
   logic [31:0] rt_q, rt_d;
   assign lr_op = (ls_lr_i != 2'b00);
`else
   logic unused_lr;
   assign unused_lr = ^{ls_lr_i, old_rt_i};
   assign lr_op     = 1'b0;
`endif

   assign misal  = ~lr_op & (((ls_size_i == 2'b01) & daddr_i[0]) |
                             (ls_size_i[1] & (daddr_i[1:0] != 2'b00)));
   assign fault  = start & misal;
   assign accept = start & ~misal;

   assign adel_o     = fault & ~is_st;
   assign ades_o     = fault & is_st;
   assign badvaddr_o = fault ? daddr_i : 32'h0;

   // request capture: bus fields are frozen at accept so they stay stable through REQ
   always_comb begin
      req_d = req_q;
`ifdef UNALIGNED_LS_EN
      lr_d = lr_q;
      rt_d = rt_q;
`endif
      if (accept) begin
         req_d.wr    = is_st;
         req_d.addr  = daddr_i;
         req_d.off   = off;
         req_d.lsize = ls_size_i;
         req_d.sgn   = ls_signed_i;
         req_d.bsize = (ls_size_i == 2'b11) ? 2'b10 : ls_size_i;
         case (ls_size_i)
            2'b00:   begin req_d.wstrb = 4'b0001 << off; req_d.wdata = {4{wdata_i[7:0]}};  end
            2'b01:   begin req_d.wstrb = 4'b0011 << off; req_d.wdata = {2{wdata_i[15:0]}}; end
            default: begin req_d.wstrb = 4'b1111;        req_d.wdata = wdata_i;            end
         endcase
`ifdef UNALIGNED_LS_EN
         lr_d = ls_lr_i;
         rt_d = old_rt_i;
         if (lr_op) begin
            req_d.addr  = {daddr_i[31:2], 2'b00};
            req_d.bsize = 2'b10;
            if (ls_lr_i == 2'b01) begin
               req_d.wstrb = 4'b1111 >> (2'd3 - off);
               req_d.wdata = wdata_i >> {2'd3 - off, 3'b000};
            end else begin
               req_d.wstrb = 4'b1111 << off;
               req_d.wdata = wdata_i << {off, 3'b000};
            end
         end
`endif
         if (!is_st) begin
            req_d.wstrb = 4'b0000;
            req_d.wdata = 32'h0;
         end
      end
   end

   always_comb begin
      lb = bus.data_rdata[{req_q.off, 3'b000} +: 8];
      lh = bus.data_rdata[{req_q.off[1], 4'b0000} +: 16];
      case (req_q.lsize)
         2'b00:   ld_fmt = {{24{req_q.sgn & lb[7]}}, lb};
         2'b01:   ld_fmt = {{16{req_q.sgn & lh[15]}}, lh};
         default: ld_fmt = bus.data_rdata;
      endcase
`ifdef UNALIGNED_LS_EN
      // LWL fills from the top, LWR from the bottom; the rest of the word keeps old rt
      if (lr_q == 2'b01)
         ld_fmt = (bus.data_rdata << {2'd3 - req_q.off, 3'b000}) |
                  (rt_q & (32'hFFFF_FFFF >> (6'd8 + {1'b0, req_q.off, 3'b000})));
      else if (lr_q != 2'b00)
         ld_fmt = (bus.data_rdata >> {req_q.off, 3'b000}) |
                  (rt_q & ~(32'hFFFF_FFFF >> {req_q.off, 3'b000}));
`endif
   end

   assign rdata_d = (state_q == S_WAIT && bus.data_data_ok && !flush_i) ? ld_fmt : rdata_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_REQ;
         S_REQ:    if (bus.data_addr_ok) state_d = flush_i ? S_CANCEL : S_WAIT;
                   else if (flush_i)     state_d = S_IDLE;
         S_WAIT:   if (flush_i)               state_d = bus.data_data_ok ? S_IDLE : S_CANCEL;
                   else if (bus.data_data_ok) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         S_CANCEL: if (bus.data_data_ok) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.data_req   = (state_q == S_REQ);
      bus.data_wr    = req_q.wr;
      bus.data_size  = req_q.bsize;
      bus.data_addr  = req_q.addr;
      bus.data_wdata = req_q.wdata;
      bus.data_wstrb = req_q.wstrb;
      stall_o        = accept | (state_q == S_REQ) | (state_q == S_WAIT) | (state_q == S_CANCEL);
      done_o         = (state_q == S_DONE);
      rdata_o        = rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q   <= '0;
         rdata_q <= 32'h0;
`ifdef UNALIGNED_LS_EN
         lr_q    <= 2'b00;
         rt_q    <= 32'h0;
`endif
      end else begin
         req_q   <= req_d;
         rdata_q <= rdata_d;
`ifdef UNALIGNED_LS_EN
         lr_q    <= lr_d;
         rt_q    <= rt_d;
`endif
      end
   end
endmodule

// File: tb/tb_lsu_sram_master.sv
// Directed bench for lsu_sram_master: per-cycle compare against a spec-level model
// of the bus request and load result, plus literal checks on timing and exceptions.
module tb_lsu_sram_master;
   logic clk = 1'b0;
   logic rst;
   logic ls_valid, ls_load, ls_store, ls_signed, flush;
   logic [1:0]  ls_size, ls_lr;
   logic [31:0] daddr, wdata, old_rt;
   logic stall, done, adel, ades;
   logic [31:0] rdata, badvaddr;

   always #5 clk = ~clk;

   lsu_sram_master_if bus();

   lsu_sram_master dut (
      .clk(clk), .rst(rst),
      .ls_valid_i(ls_valid), .ls_load_i(ls_load), .ls_store_i(ls_store),
      .ls_size_i(ls_size), .ls_signed_i(ls_signed), .ls_lr_i(ls_lr),
      .daddr_i(daddr), .wdata_i(wdata), .old_rt_i(old_rt), .flush_i(flush),
      .bus(bus.master),
      .stall_o(stall), .done_o(done), .rdata_o(rdata),
      .adel_o(adel), .ades_o(ades), .badvaddr_o(badvaddr)
   );

`ifdef UNALIGNED_LS_EN
   localparam bit UNAL = 1'b1;
`else
   localparam bit UNAL = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // model of the access in flight
   logic        m_wr, m_sgn, m_done_ok;
   logic [1:0]  m_size, m_lsize, m_off, m_lr;
   logic [31:0] m_addr, m_wdata, m_rt, m_raw;
   logic [3:0]  m_wstrb;

   function automatic logic [31:0] f_load(input logic [31:0] m, input logic [1:0] sz,
                                          input logic sg, input logic [1:0] o,
                                          input logic [1:0] lr, input logic [31:0] rt);
      logic [31:0] s;
      if (lr == 2'b01) begin
         case (o)
            2'd0: return {m[7:0], rt[23:0]};
            2'd1: return {m[15:0], rt[15:0]};
            2'd2: return {m[23:0], rt[7:0]};
            default: return m;
         endcase
      end
      if (lr == 2'b10) begin
         case (o)
            2'd0: return m;
            2'd1: return {rt[31:24], m[31:8]};
            2'd2: return {rt[31:16], m[31:16]};
            default: return {rt[31:8], m[31:24]};
         endcase
      end
      s = m >> (8 * o);
      if (sz == 2'b00) return sg ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
      if (sz == 2'b01) return sg ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
      return m;
   endfunction

   task automatic start(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [1:0] lr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rt);
      logic [1:0] elr;
      ls_valid = 1'b1; ls_load = ld; ls_store = st; ls_size = sz; ls_signed = sg;
      ls_lr = lr; daddr = a; wdata = wd; old_rt = rt;
      elr     = UNAL ? lr : 2'b00;
      m_wr    = st & ~ld;
      m_off   = a[1:0];
      m_lsize = sz; m_sgn = sg; m_lr = elr; m_rt = rt;
      m_addr  = (elr != 2'b00) ? {a[31:2], 2'b00} : a;
      m_size  = (elr != 2'b00 || sz == 2'b11) ? 2'd2 : sz;
      if (elr == 2'b01) begin
         m_wstrb = (a[1:0] == 0) ? 4'b0001 : (a[1:0] == 1) ? 4'b0011 : (a[1:0] == 2) ? 4'b0111 : 4'b1111;
         m_wdata = wd >> (8 * (3 - a[1:0]));
      end else if (elr == 2'b10) begin
         m_wstrb = (a[1:0] == 0) ? 4'b1111 : (a[1:0] == 1) ? 4'b1110 : (a[1:0] == 2) ? 4'b1100 : 4'b1000;
         m_wdata = wd << (8 * a[1:0]);
      end else if (sz == 2'b00) begin
         m_wstrb = 4'b0001 << a[1:0]; m_wdata = {4{wd[7:0]}};
      end else if (sz == 2'b01) begin
         m_wstrb = a[1] ? 4'b1100 : 4'b0011; m_wdata = {2{wd[15:0]}};
      end else begin
         m_wstrb = 4'b1111; m_wdata = wd;
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.data_req) begin
            chk("bus_addr", bus.data_addr, m_addr);
            chk("bus_wr", {31'h0, bus.data_wr}, {31'h0, m_wr});
            chk("bus_size", {30'h0, bus.data_size}, {30'h0, m_size});
            chk("bus_wstrb", {28'h0, bus.data_wstrb}, m_wr ? {28'h0, m_wstrb} : 32'h0);
            if (m_wr) chk("bus_wdata", bus.data_wdata, m_wdata);
         end
         if (done) begin
            if (!m_done_ok) chk("spurious_done", {31'h0, done}, 32'h0);
            else if (!m_wr) chk("model_rdata", rdata, f_load(m_raw, m_lsize, m_sgn, m_off, m_lr, m_rt));
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   // zero-wait-state access with literal expectations on the request and the result
   task automatic fast(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                       input logic sg, input logic [1:0] lr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rt, input logic [31:0] raw,
                       input logic [31:0] e_addr, input logic [3:0] e_strb,
                       input logic [31:0] e_wd, input logic [31:0] e_rd);
      cyc(); start(ld, st, sz, sg, lr, a, wd, rt); m_done_ok = 1'b1;
      @(negedge clk); chk({nm, "_accept_stall"}, {31'h0, stall}, 32'h1);
      cyc(); ls_valid = 1'b0; bus.data_addr_ok = 1'b1;
      @(negedge clk);
      chk({nm, "_req"}, {31'h0, bus.data_req}, 32'h1);
      chk({nm, "_addr"}, bus.data_addr, e_addr);
      chk({nm, "_strb"}, {28'h0, bus.data_wstrb}, {28'h0, e_strb});
      if (st) chk({nm, "_wdata"}, bus.data_wdata, e_wd);
      cyc(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = raw; m_raw = raw;
      cyc(); bus.data_data_ok = 1'b0;
      @(negedge clk);
      chk({nm, "_done"}, {31'h0, done}, 32'h1);
      if (ld) chk({nm, "_rdata"}, rdata, e_rd);
      cyc(); m_done_ok = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; ls_valid = 1'b0; ls_load = 1'b0; ls_store = 1'b0;
      ls_size = 2'b00; ls_signed = 1'b0; ls_lr = 2'b00; daddr = 0; wdata = 0; old_rt = 0;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
      m_done_ok = 1'b0; m_wr = 1'b0; m_raw = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_req", {31'h0, bus.data_req}, 32'h0);
      chk("rst_outs", {done, adel, ades, bus.data_wr, bus.data_wstrb}, 32'h0);
      chk("rst_addr", bus.data_addr, 32'h0);
      chk("rst_rdata", rdata, 32'h0);

      // signed byte load, minimum latency
      cyc(); start(1, 0, 2'b00, 1, 2'b00, 32'h1003, 0, 0); m_done_ok = 1'b1;
      @(negedge clk); chk("lb_t0_stall", {31'h0, stall}, 32'h1); chk("lb_t0_req", {31'h0, bus.data_req}, 32'h0);
      cyc(); ls_valid = 1'b0; bus.data_addr_ok = 1'b1;
      @(negedge clk);
      chk("lb_t1_req", {31'h0, bus.data_req}, 32'h1);
      chk("lb_t1_size", {30'h0, bus.data_size}, 32'h0);
      chk("lb_t1_strb", {28'h0, bus.data_wstrb}, 32'h0);
      chk("lb_t1_addr", bus.data_addr, 32'h1003);
      cyc(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h80AABBCC; m_raw = 32'h80AABBCC;
      @(negedge clk); chk("lb_t2_stall", {31'h0, stall}, 32'h1); chk("lb_t2_done", {31'h0, done}, 32'h0);
      cyc(); bus.data_data_ok = 1'b0;
      @(negedge clk);
      chk("lb_t3_done", {31'h0, done}, 32'h1);
      chk("lb_t3_rdata", rdata, 32'hFFFFFF80);
      chk("lb_t3_stall", {31'h0, stall}, 32'h0);
      cyc(); @(negedge clk); chk("lb_t4_done", {31'h0, done}, 32'h0); m_done_ok = 1'b0;

      // half store with addr_ok withheld for three cycles
      cyc(); start(0, 1, 2'b01, 0, 2'b00, 32'h2002, 32'h1234ABCD, 0); m_done_ok = 1'b1;
      @(negedge clk); chk("sh_stall", {31'h0, stall}, 32'h1);
      cyc(); ls_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("sh_req_held", {31'h0, bus.data_req}, 32'h1);
         chk("sh_wdata", bus.data_wdata, 32'hABCDABCD);
         chk("sh_strb", {28'h0, bus.data_wstrb}, 32'hC);
         chk("sh_wr", {31'h0, bus.data_wr}, 32'h1);
         cyc();
      end
      bus.data_addr_ok = 1'b1;
      @(negedge clk); chk("sh_req_ack", {31'h0, bus.data_req}, 32'h1);
      cyc(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
      @(negedge clk); chk("sh_wait_req", {31'h0, bus.data_req}, 32'h0); chk("sh_wait_stall", {31'h0, stall}, 32'h1);
      cyc(); bus.data_data_ok = 1'b0;
      @(negedge clk); chk("sh_done", {31'h0, done}, 32'h1);
      cyc(); m_done_ok = 1'b0;

      // more formats
      fast("lhu", 1, 0, 2'b01, 0, 2'b00, 32'h8002, 0, 0, 32'h81234567, 32'h8002, 4'h0, 0, 32'h00008123);
      fast("lh",  1, 0, 2'b01, 1, 2'b00, 32'h8000, 0, 0, 32'h1234F00D, 32'h8000, 4'h0, 0, 32'hFFFFF00D);
      fast("lbu", 1, 0, 2'b00, 0, 2'b00, 32'h8001, 0, 0, 32'h1234F00D, 32'h8001, 4'h0, 0, 32'h000000F0);
      fast("lw",  1, 0, 2'b11, 1, 2'b00, 32'h8004, 0, 0, 32'hDEADBEEF, 32'h8004, 4'h0, 0, 32'hDEADBEEF);
      fast("sb",  0, 1, 2'b00, 0, 2'b00, 32'h9001, 32'h000000A5, 0, 0, 32'h9001, 4'b0010, 32'hA5A5A5A5, 0);
      fast("sw",  0, 1, 2'b10, 0, 2'b00, 32'hA000, 32'h12345678, 0, 0, 32'hA000, 4'b1111, 32'h12345678, 0);

      // address errors
      cyc(); start(1, 0, 2'b10, 0, 2'b00, 32'h3001, 0, 0);
      @(negedge clk);
      chk("adel", {31'h0, adel}, 32'h1); chk("adel_ades", {31'h0, ades}, 32'h0);
      chk("adel_bva", badvaddr, 32'h3001); chk("adel_stall", {31'h0, stall}, 32'h0);
      cyc(); ls_valid = 1'b0;
      @(negedge clk); chk("adel_noreq", {31'h0, bus.data_req}, 32'h0);
      cyc(); start(0, 1, 2'b01, 0, 2'b00, 32'h5001, 32'h1, 0);
      @(negedge clk); chk("ades", {31'h0, ades}, 32'h1); chk("ades_bva", badvaddr, 32'h5001);
      cyc(); start(1, 0, 2'b01, 0, 2'b00, 32'h5003, 0, 0); flush = 1'b1;
      @(negedge clk); chk("flush_adel", {31'h0, adel}, 32'h0);
      cyc(); start(1, 0, 2'b10, 0, 2'b00, 32'h6100, 0, 0);
      @(negedge clk); chk("flush_idle_stall", {31'h0, stall}, 32'h0);
      cyc(); ls_valid = 1'b0; flush = 1'b0;
      @(negedge clk); chk("flush_idle_noreq", {31'h0, bus.data_req}, 32'h0);

      // flush while REQ without addr_ok
      cyc(); start(1, 0, 2'b10, 0, 2'b00, 32'hB000, 0, 0);
      cyc(); ls_valid = 1'b0; flush = 1'b1;
      @(negedge clk); chk("freq_req", {31'h0, bus.data_req}, 32'h1);
      cyc(); flush = 1'b0;
      @(negedge clk); chk("freq_dropped", {31'h0, bus.data_req}, 32'h0); chk("freq_stall", {31'h0, stall}, 32'h0);

      // flush in WAIT, data_ok two cycles later
      cyc(); start(1, 0, 2'b10, 0, 2'b00, 32'h6000, 0, 0);
      cyc(); ls_valid = 1'b0; bus.data_addr_ok = 1'b1;
      cyc(); bus.data_addr_ok = 1'b0; flush = 1'b1;
      @(negedge clk); chk("cx_wait_stall", {31'h0, stall}, 32'h1);
      cyc(); flush = 1'b0;
      @(negedge clk); chk("cx_cancel_stall", {31'h0, stall}, 32'h1);
      cyc(); bus.data_data_ok = 1'b1; bus.data_rdata = 32'h55555555;
      @(negedge clk); chk("cx_dok_stall", {31'h0, stall}, 32'h1); chk("cx_dok_done", {31'h0, done}, 32'h0);
      cyc(); bus.data_data_ok = 1'b0;
      @(negedge clk); chk("cx_idle_stall", {31'h0, stall}, 32'h0); chk("cx_idle_done", {31'h0, done}, 32'h0);

      // reset while WAIT; the late response must be ignored
      cyc(); start(1, 0, 2'b10, 0, 2'b00, 32'h7000, 0, 0);
      cyc(); ls_valid = 1'b0; bus.data_addr_ok = 1'b1;
      cyc(); bus.data_addr_ok = 1'b0; rst = 1'b1;
      cyc(); rst = 1'b0;
      @(negedge clk);
      chk("rw_stall", {31'h0, stall}, 32'h0); chk("rw_req", {31'h0, bus.data_req}, 32'h0);
      chk("rw_addr", bus.data_addr, 32'h0); chk("rw_rdata", rdata, 32'h0);
      cyc(); bus.data_data_ok = 1'b1; bus.data_rdata = 32'h12345678;
      @(negedge clk); chk("rw_late_stall", {31'h0, stall}, 32'h0);
      cyc(); bus.data_data_ok = 1'b0;
      @(negedge clk); chk("rw_late_done", {31'h0, done}, 32'h0);
      fast("lw_after_rst", 1, 0, 2'b10, 0, 2'b00, 32'hC008, 0, 0, 32'hCAFEF00D, 32'hC008, 4'h0, 0, 32'hCAFEF00D);

`ifdef UNALIGNED_LS_EN
      fast("lwr", 1, 0, 2'b10, 0, 2'b10, 32'h4001, 0, 32'h11223344, 32'hAABBCCDD, 32'h4000, 4'h0, 0, 32'h11AABBCC);
      fast("lwl", 1, 0, 2'b10, 0, 2'b01, 32'h4001, 0, 32'h11223344, 32'hAABBCCDD, 32'h4000, 4'h0, 0, 32'hCCDD3344);
      fast("swl", 0, 1, 2'b10, 0, 2'b01, 32'h4002, 32'hAABBCCDD, 0, 0, 32'h4000, 4'b0111, 32'h00AABBCC, 0);
      fast("swr", 0, 1, 2'b10, 0, 2'b10, 32'h4003, 32'hAABBCCDD, 0, 0, 32'h4000, 4'b1000, 32'hDD000000, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lsu_sram_master.md
Name: lsu_sram_master

Overview:
- Load/store unit. Consumes the effective data address from the execute stage, together with the access type and store data.
- Checks alignment and raises AdEL/AdES.
- Drives a single-outstanding SRAM-like data bus master (req / addr_ok / data_ok).
- Returns byte-lane-extracted, sign- or zero-extended load data to the memory stage. Stalls the pipeline while an access is in flight.

Parameters:
- none

Ports:
- clk  in  1  clock (all logic rising-edge)
- rst  in  1  reset, synchronous, active-high
- ls_valid  in  1  access request from EX; fields held stable by upstream while stall=1
- ls_load  in  1  load access
- ls_store  in  1  store access
- ls_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ls_signed  in  1  sign-extend load result
- ls_lr  in  2  00 normal, 01 LWL/SWL, 10 LWR/SWR; used only with UNALIGNED_LS_EN
- daddr  in  32  effective address
- wdata  in  32  store data (rt)
- old_rt  in  32  current rt value for LWL/LWR merge; used only with UNALIGNED_LS_EN
- flush  in  1  pipeline flush (exception/eret)
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  bus address
- data_wdata  out  32  lane-replicated store data
- data_wstrb  out  4  byte strobes (writes only; 0 for reads)
- data_addr_ok  in  1  address handshake accepted
- data_data_ok  in  1  response (read data valid / write complete)
- data_rdata  in  32  raw read word
- stall  out  1  hold pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  32  formatted load result; valid when done=1
- adel  out  1  load address error
- ades  out  1  store address error
- badvaddr  out  32  faulting address; valid with adel/ades

Behaviour:
- States: IDLE, REQ, WAIT, DONE, CANCEL.
- Reset: state=IDLE; all outputs 0.
- Reset mid-operation: immediate IDLE; any outstanding response is ignored.
- IDLE, ls_valid & (ls_load | ls_store):
  - Alignment check: half needs daddr[0]=0; word needs daddr[1:0]=0; byte is always aligned.
  - Misaligned: adel (load) or ades (store) asserted combinationally in the same cycle, badvaddr=daddr. No request, stall=0, stay IDLE.
  - Aligned: stall=1. Register request fields; next state REQ.
- REQ:
  - data_req=1; all bus outputs held stable until data_addr_ok.
  - addr_ok & !flush -> WAIT.
  - addr_ok & flush -> CANCEL.
  - !addr_ok & flush -> IDLE; data_req drops next cycle.
- WAIT:
  - data_req=0.
  - data_ok & !flush -> DONE: rdata registered from data_rdata.
  - flush (with or without data_ok): data_ok present -> IDLE; otherwise -> CANCEL.
- DONE: done=1, stall=0, rdata valid for exactly this cycle; -> IDLE.
- CANCEL: stall=1; wait for data_ok, discard the response, no done pulse; -> IDLE.
- flush while in IDLE: suppresses any new request and exception in that cycle.
- stall=1 in IDLE (when starting an aligned access), REQ, WAIT and CANCEL; 0 otherwise.
- Minimum latency (addr_ok and data_ok both single-cycle): accept at T0, req at T1, WAIT at T2, done at T3.
- Store formatting, with o = daddr[1:0]:
  - byte: wstrb = 0001<<o, wdata = {4{wdata[7:0]}}.
  - half: wstrb = 0011<<o, wdata = {2{wdata[15:0]}}.
  - word: wstrb = 1111.
  - data_addr = daddr unmodified.
- Load formatting:
  - shifted = data_rdata >> 8*o.
  - byte/half: zero- or sign-extend by ls_signed.
  - word: pass through.

Optional Feature:
- Macro: UNALIGNED_LS_EN.
- Enabled:
  - ls_lr != 00 bypasses the alignment check.
  - Request: data_addr = {daddr[31:2], 2'b00}, data_size = 2.
  - With n = daddr[1:0]:
    - LWL result: n0 {m[7:0], rt[23:0]}; n1 {m[15:0], rt[15:0]}; n2 {m[23:0], rt[7:0]}; n3 m.
    - LWR result: n0 m; n1 {rt[31:24], m[31:8]}; n2 {rt[31:16], m[31:16]}; n3 {rt[31:8], m[31:24]}.
    - rt = old_rt captured at accept.
    - SWL: wstrb = 0001, 0011, 0111, 1111 for n = 0..3; data_wdata = wdata >> 8*(3-n).
    - SWR: wstrb = 1111, 1110, 1100, 1000 for n = 0..3; data_wdata = wdata << 8*n.
- Disabled: ls_lr and old_rt ignored; every access is treated as normal.

Test Plan:
- Load byte, signed, daddr=0x1003, rdata=0x80AABBCC -> data_size=0, wstrb=0; done at T3 with rdata=0xFFFFFF80.
- Store half, daddr=0x2002, wdata=0x1234ABCD -> data_wdata=0xABCDABCD, wstrb=1100, data_wr=1; data_req held 3 cycles while addr_ok is withheld.
- Load word, daddr=0x3001 -> adel=1 and badvaddr=0x3001 same cycle; no data_req; stall=0.
- Load word accepted, flush in WAIT, data_ok 2 cycles later -> CANCEL entered; no done; stall=1 until data_ok, then IDLE.
- rst asserted in WAIT -> next cycle state IDLE, all outputs 0; a later data_ok is ignored.
- (UNALIGNED_LS_EN) LWR, daddr=0x4001, old_rt=0x11223344, rdata=0xAABBCCDD -> data_addr=0x4000, rdata=0x11AABBCC.
